// File: rtl/sbox_word_arbiter.sv
// Shares one 32-bit S-box word unit between 128-bit SubBytes (four passes)
// and 32-bit SubWord (one pass), with round-robin grant on ties.
module sbox_word_arbiter (
    input  logic         clk,
    input  logic         rst,
    input  logic         d_valid,
    output logic         d_ready,
    input  logic [127:0] d_in,
    output logic         d_out_valid,
    output logic [127:0] d_out,
    input  logic         k_valid,
    output logic         k_ready,
    input  logic [31:0]  k_in,
    output logic         k_out_valid,
    output logic [31:0]  k_out,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        KEY  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_DATA = 1'b0,
        GNT_KEY  = 1'b1
    } grant_t;

    state_t       state_q, state_d;
    grant_t       last_q, last_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] dbuf_q, dbuf_d;
    logic [31:0]  kbuf_q, kbuf_d;
    logic [127:0] res_q, res_d;
    logic [127:0] d_out_q, d_out_d;
    logic         d_out_valid_q, d_out_valid_d;
    logic [31:0]  k_out_q, k_out_d;
    logic         k_out_valid_q, k_out_valid_d;
    logic         d_acc, k_acc;

    // Each ready looks only at the other side's valid, so ties resolve
    // to whichever requester was not served last.
    always_comb begin
        d_ready = (state_q == IDLE) && (!k_valid || last_q == GNT_KEY);
        k_ready = (state_q == IDLE) && (!d_valid || last_q == GNT_DATA);
        d_acc   = d_valid && d_ready;
        k_acc   = k_valid && k_ready;
    end

    always_comb begin
        sb_in = 32'd0;
        if (state_q == DATA) begin
            unique case (cnt_q)
                2'd0: sb_in = dbuf_q[127:96];
                2'd1: sb_in = dbuf_q[95:64];
                2'd2: sb_in = dbuf_q[63:32];
                2'd3: sb_in = dbuf_q[31:0];
                default: sb_in = 32'd0;
            endcase
        end else if (state_q == KEY) begin
            sb_in = kbuf_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        dbuf_d        = dbuf_q;
        kbuf_d        = kbuf_q;
        res_d         = res_q;
        d_out_d       = d_out_q;
        k_out_d       = k_out_q;
        d_out_valid_d = 1'b0;
        k_out_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_acc) begin
                    dbuf_d  = d_in;
                    cnt_d   = 2'd0;
                    last_d  = GNT_DATA;
                    state_d = DATA;
                end else if (k_acc) begin
                    kbuf_d  = k_in;
                    last_d  = GNT_KEY;
                    state_d = KEY;
                end
            end
            DATA: begin
                unique case (cnt_q)
                    2'd0: res_d[127:96] = sb_out;
                    2'd1: res_d[95:64]  = sb_out;
                    2'd2: res_d[63:32]  = sb_out;
                    2'd3: res_d[31:0]   = sb_out;
                    default: res_d = res_q;
                endcase
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    d_out_d       = res_d;
                    d_out_valid_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            KEY: begin
                k_out_d       = sb_out;
                k_out_valid_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= GNT_KEY;
            cnt_q         <= 2'd0;
            dbuf_q        <= 128'd0;
            kbuf_q        <= 32'd0;
            res_q         <= 128'd0;
            d_out_q       <= 128'd0;
            k_out_q       <= 32'd0;
            d_out_valid_q <= 1'b0;
            k_out_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            dbuf_q        <= dbuf_d;
            kbuf_q        <= kbuf_d;
            res_q         <= res_d;
            d_out_q       <= d_out_d;
            k_out_q       <= k_out_d;
            d_out_valid_q <= d_out_valid_d;
            k_out_valid_q <= k_out_valid_d;
        end
    end

    assign d_out       = d_out_q;
    assign d_out_valid = d_out_valid_q;
    assign k_out       = k_out_q;
    assign k_out_valid = k_out_valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_word_arbiter.sv
// Directed bench for sbox_word_arbiter; the shared S-box is modelled
// arithmetically (GF(2^8) inverse plus affine map).
module tb_sbox_word_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         d_valid;
    logic         d_ready;
    logic [127:0] d_in;
    logic         d_out_valid;
    logic [127:0] d_out;
    logic         k_valid;
    logic         k_ready;
    logic [31:0]  k_in;
    logic         k_out_valid;
    logic [31:0]  k_out;
    logic [31:0]  sb_in;
    logic [31:0]  sb_out;
    logic         busy;

    int n_err = 0;
    int n_chk = 0;

    localparam logic [127:0] DV = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
    localparam logic [127:0] DR = 128'hd4e0b81e27bfb44111985d52aef1e530;

    sbox_word_arbiter dut (
        .clk(clk), .rst(rst),
        .d_valid(d_valid), .d_ready(d_ready), .d_in(d_in),
        .d_out_valid(d_out_valid), .d_out(d_out),
        .k_valid(k_valid), .k_ready(k_ready), .k_in(k_in),
        .k_out_valid(k_out_valid), .k_out(k_out),
        .sb_in(sb_in), .sb_out(sb_out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'd0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] inv = 8'd0;
        logic [7:0] r1, r2, r3, r4;
        if (v != 8'd0)
            for (int i = 1; i < 256; i++)
                if (gmul(v, 8'(i)) == 8'd1) inv = 8'(i);
        r1 = {inv[6:0], inv[7]};
        r2 = {inv[5:0], inv[7:6]};
        r3 = {inv[4:0], inv[7:5]};
        r4 = {inv[3:0], inv[7:4]};
        return inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    endfunction

    always_comb begin
        sb_out = {sbox(sb_in[31:24]), sbox(sb_in[23:16]),
                  sbox(sb_in[15:8]), sbox(sb_in[7:0])};
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] dv;
        int jobs;
        int pulses;
        int exp_cyc;

        rst = 1'b1;
        d_valid = 1'b0; d_in = '0;
        k_valid = 1'b0; k_in = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_dout", d_out, 128'd0);
        chk("rst_kout", 128'(k_out), 128'd0);
        chk("rst_sbin", 128'(sb_in), 128'd0);
        chk("rst_dv", 128'(d_out_valid), 128'd0);
        chk("rst_kv", 128'(k_out_valid), 128'd0);
        chk("rst_drdy", 128'(d_ready), 128'd1);
        chk("rst_krdy", 128'(k_ready), 128'd1);

        // data only
        dv = DV;
        d_valid = 1'b1; d_in = DV;
        tick();
        d_valid = 1'b0; d_in = '1;
        for (int i = 0; i < 4; i++) begin
            chk("d_sbin", 128'(sb_in), 128'(dv[127-32*i -: 32]));
            chk("d_busy", 128'(busy), 128'd1);
            chk("d_vlo", 128'(d_out_valid), 128'd0);
            chk("d_rdy", 128'(d_ready), 128'd0);
            tick();
        end
        chk("d_vhi", 128'(d_out_valid), 128'd1);
        chk("d_out", d_out, DR);
        chk("d_idle", 128'(busy), 128'd0);
        tick();
        chk("d_pulse", 128'(d_out_valid), 128'd0);
        chk("d_hold", d_out, DR);

        // key only
        k_valid = 1'b1; k_in = 32'hcf4f3c09;
        tick();
        k_valid = 1'b0; k_in = 32'h0;
        chk("k_sbin", 128'(sb_in), 128'h cf4f3c09);
        chk("k_busy", 128'(busy), 128'd1);
        chk("k_vlo", 128'(k_out_valid), 128'd0);
        tick();
        chk("k_vhi", 128'(k_out_valid), 128'd1);
        chk("k_out", 128'(k_out), 128'h8a84eb01);
        k_valid = 1'b1; k_in = 32'h0;
        tick();
        k_valid = 1'b0;
        tick();
        chk("k_zero", 128'(k_out), 128'h63636363);
        tick();
        chk("k_pulse", 128'(k_out_valid), 128'd0);

        // tie after reset: strict alternation starting with data
        rst = 1'b1; tick(); rst = 1'b0;
        d_valid = 1'b1; d_in = DV;
        k_valid = 1'b1; k_in = 32'hcf4f3c09;
        jobs = 0;
        for (int c = 1; c <= 28; c++) begin
            tick();
            if (d_out_valid) begin
                exp_cyc = 5 + 7 * (jobs / 2);
                chk("alt_kind_d", 128'(jobs % 2), 128'd0);
                chk("alt_cyc_d", 128'(c), 128'(exp_cyc));
                chk("alt_dout", d_out, DR);
                jobs++;
            end
            if (k_out_valid) begin
                exp_cyc = 7 + 7 * (jobs / 2);
                chk("alt_kind_k", 128'(jobs % 2), 128'd1);
                chk("alt_cyc_k", 128'(c), 128'(exp_cyc));
                chk("alt_kout", 128'(k_out), 128'h8a84eb01);
                jobs++;
            end
        end
        d_valid = 1'b0; k_valid = 1'b0;
        chk("alt_jobs", 128'(jobs), 128'd8);
        tick();
        chk("alt_idle", 128'(busy), 128'd0);

        // key waits during DATA, value taken at acceptance edge
        d_valid = 1'b1; d_in = DV;
        tick();
        d_valid = 1'b0;
        k_valid = 1'b1; k_in = 32'h11111111;
        for (int c = 1; c <= 4; c++) begin
            chk("kw_rdy", 128'(k_ready), 128'd0);
            if (c == 3) k_in = 32'h0;
            tick();
        end
        chk("kw_dv", 128'(d_out_valid), 128'd1);
        chk("kw_rdy_idle", 128'(k_ready), 128'd1);
        k_in = 32'hcf4f3c09;
        tick();
        k_valid = 1'b0; k_in = 32'hffffffff;
        chk("kw_sbin", 128'(sb_in), 128'hcf4f3c09);
        tick();
        chk("kw_v", 128'(k_out_valid), 128'd1);
        chk("kw_out", 128'(k_out), 128'h8a84eb01);

        // reset in the middle of a data job
        d_valid = 1'b1; d_in = DV;
        tick();
        d_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", 128'(busy), 128'd0);
        chk("mr_dout", d_out, 128'd0);
        chk("mr_kout", 128'(k_out), 128'd0);
        chk("mr_sbin", 128'(sb_in), 128'd0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (d_out_valid) pulses++;
            tick();
        end
        chk("mr_nopulse", 128'(pulses), 128'd0);
        d_valid = 1'b1; d_in = 128'd0;
        tick();
        d_valid = 1'b0;
        repeat (4) tick();
        chk("mr_next_v", 128'(d_out_valid), 128'd1);
        chk("mr_next", d_out, {16{8'h63}});

        // idle with held results
        k_valid = 1'b1; k_in = 32'h0;
        tick();
        k_valid = 1'b0;
        tick();
        chk("id_kout", 128'(k_out), 128'h63636363);
        tick();
        for (int c = 0; c < 20; c++) begin
            chk("id_sbin", 128'(sb_in), 128'd0);
            chk("id_busy", 128'(busy), 128'd0);
            chk("id_dv", 128'(d_out_valid), 128'd0);
            chk("id_kv", 128'(k_out_valid), 128'd0);
            chk("id_dhold", d_out, {16{8'h63}});
            chk("id_khold", 128'(k_out), 128'h63636363);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sbox_word_arbiter.md
# sbox_word_arbiter

Time-multiplexed controller for a single 32-bit (4-byte) S-box word unit shared by the cipher datapath (128-bit SubBytes, four word passes) and the key schedule (32-bit SubWord, one pass). Accepts one job at a time through valid/ready handshakes, arbitrates round-robin between the two requesters, sequences the word passes through the external S-box, and returns the substituted result with a one-cycle valid pulse. It sits between the round controller/key expansion logic and the shared S-box, replacing two full 128-bit plus 32-bit S-box arrays with one 32-bit array.

## Interface
- Parameters: none; widths are fixed by AES-128.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- d_valid  in  1  data SubBytes request
- d_ready  out  1  data request accepted when d_valid && d_ready at clk edge
- d_in  in  128  state to substitute; bits [127:96] are word 0
- d_out_valid  out  1  one-cycle pulse, d_out valid
- d_out  out  128  substituted state; holds until next data result
- k_valid  in  1  key SubWord request
- k_ready  out  1  key request accepted when k_valid && k_ready at clk edge
- k_in  in  32  word to substitute
- k_out_valid  out  1  one-cycle pulse, k_out valid
- k_out  out  32  substituted word; holds until next key result
- sb_in  out  32  word driven to shared S-box
- sb_out  in  32  S-box result, combinational from sb_in within the same cycle
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, DATA, KEY. Reset -> IDLE.
- Reset values: d_ready/k_ready per IDLE rules below; d_out_valid=0, k_out_valid=0, d_out=0, k_out=0, sb_in=0, busy=0, word counter=0, last-grant=KEY (so data wins the first tie).
- IDLE: d_ready = !k_valid || last==KEY; k_ready = !d_valid || last==DATA. Both readys are 0 outside IDLE. Readys must not depend combinationally on their own valid.
- Tie (both valid in IDLE): grant the requester not granted last; last-grant updates on every accept.
- Data accept: capture d_in into input buffer, counter=0, -> DATA.
- DATA: sb_in = buffer word[counter] (word 0 = [127:96]). Each edge writes sb_out into result word[counter], counter++. After the edge processing counter==3: -> IDLE, d_out updated with full result, d_out_valid=1 for one cycle.
- Key accept: capture k_in, -> KEY. KEY: sb_in = captured word; at edge k_out <= sb_out, k_out_valid=1 for one cycle, -> IDLE.
- Jobs are non-preemptive; a requester keeping valid high while not ready is held (inputs may change before acceptance; only the accepted value is used).
- sb_in = 0 in IDLE.
- rst mid-job: job discarded, no result pulse, all state to reset values on that edge.

## Timing
- Accept at edge T: DATA occupies cycles T+1..T+4; d_out_valid high in cycle T+5; state IDLE in T+5, so a new accept can occur at edge ending T+5. Data latency 5 cycles, max throughput one data job per 5 cycles.
- Key: KEY in T+1, k_out_valid high in T+2. Latency 2, throughput one per 2 cycles.
- Back-to-back alternating (both valid continuously): data, key, data, key… grants, strictly alternating.
- d_out/k_out registered; no combinational path from d_in/k_in to outputs.

## Test plan
- Bench wires sb_in/sb_out to a reference 4-byte AES S-box model.
- Data only: d_in=19a09ae93df4c6f8e3e28d48be2b2a08 accepted at edge 0 -> d_out=d4e0b81e27bfb44111985d52aef1e530 with d_out_valid in cycle 5 only; sb_in sequence 19a09ae9, 3df4c6f8, e3e28d48, be2b2a08.
- Key only: k_in=cf4f3c09 -> k_out=8a84eb01, k_out_valid in cycle 2; k_in=00000000 -> 63636363.
- Simultaneous first requests after reset: data granted first (5 cycles), then key accepted in the IDLE cycle of the data result; next tie goes to data again; verify strict alternation over 8 jobs.
- Key valid arriving during DATA: k_ready=0 until IDLE; k_in changed while waiting -> result uses value present at acceptance edge.
- rst asserted in cycle T+2 of a data job -> no d_out_valid, d_out=0, busy=0, next job completes correctly.
- Idle check: no valid for 20 cycles -> sb_in=0, busy=0, both valid pulses 0, outputs hold last results.
